// File: rtl/iterative_subtractor_64.sv
// Multi-cycle two's-complement subtractor: Y = A - B computed CHUNK bits per
// cycle with a registered ripple borrow, plus Y86-style ZF/SF/OF flags.
module iterative_subtractor_64 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             overflow,
  output logic             zf,
  output logic             sf
);

  localparam int unsigned NCYC = WIDTH / CHUNK;
  localparam int unsigned CntW = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NCYC - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  // Holds ~B so each chunk is a plain add with carry.
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             of_q, of_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK:0]   chunk_sum;
  logic             a_msb;
  logic             b_msb;

  // Chunk adder, next-state logic and result capture on the completing edge.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    y_d     = y_q;
    of_d    = of_q;
    zf_d    = zf_q;
    sf_d    = sf_q;

    chunk_a   = op_a_q[cnt_q*CHUNK +: CHUNK];
    chunk_b   = op_b_q[cnt_q*CHUNK +: CHUNK];
    chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
    a_msb     = op_a_q[WIDTH-1];
    b_msb     = ~op_b_q[WIDTH-1];

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          op_a_d  = A;
          op_b_d  = ~B;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        part_d[cnt_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          // part_d already includes the final chunk; the last carry-out is dropped.
          y_d  = part_d;
          zf_d = (part_d == '0);
          sf_d = part_d[WIDTH-1];
          of_d = (a_msb != b_msb) && (part_d[WIDTH-1] != a_msb);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      part_q  <= '0;
      y_q     <= '0;
      of_q    <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      y_q     <= y_d;
      of_q    <= of_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
    end
  end

  // Status decoded from state; results come straight from the held registers.
  always_comb begin
    busy     = (state_q == StRun);
    done     = (state_q == StDone);
    Y        = y_q;
    overflow = of_q;
    zf       = zf_q;
    sf       = sf_q;
  end

endmodule
